neuron_accumulator: RTL and testbench



---
 rtl/nn_pkg.sv | 20 ++
 rtl/sat_relu.sv | 33 +++
 rtl/neuron_accumulator.sv | 118 +++++++++++
 tb/tb_neuron_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths, state encoding and saturation limits for the neural datapath.
package nn_pkg;

   localparam int PROD_W    = 26;
   localparam int CNT_W     = 10;
   localparam int ACC_W     = PROD_W + CNT_W;
   localparam int OUT_W     = 26;
   localparam int NUM_TERMS = 784;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      BIAS  = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;

   // Largest and smallest signed values representable at OUT_W.
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/sat_relu.sv
// Optional ReLU followed by signed saturation from ACC_W down to OUT_W.
module sat_relu #(
   parameter int ACC_W   = nn_pkg::ACC_W,
   parameter int OUT_W   = nn_pkg::OUT_W,
   parameter bit RELU_EN = 1'b1
) (
   input  logic [ACC_W-1:0] sum_i,
   output logic [OUT_W-1:0] value_o,
   output logic             sat_o
);

   // OUT_W limits sign-extended to the accumulator width for comparison.
   localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] MAX_O = MAX_A[OUT_W-1:0];
   localparam logic [OUT_W-1:0] MIN_O = MIN_A[OUT_W-1:0];

   // ReLU takes priority; a clamped negative is not reported as saturation.
   always_comb begin
      value_o = sum_i[OUT_W-1:0];
      sat_o   = 1'b0;
      if (RELU_EN && sum_i[ACC_W-1]) begin
         value_o = '0;
      end else if ($signed(sum_i) > MAX_A) begin
         value_o = MAX_O;
         sat_o   = 1'b1;
      end else if ($signed(sum_i) < MIN_A) begin
         value_o = MIN_O;
         sat_o   = 1'b1;
      end
   end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums NUM_TERMS signed products, adds a bias, applies ReLU/saturation and
// holds the result on a valid/ready interface until it is taken.
module neuron_accumulator #(
   parameter int PROD_W    = nn_pkg::PROD_W,
   parameter int NUM_TERMS = nn_pkg::NUM_TERMS,
   parameter int CNT_W     = nn_pkg::CNT_W,
   parameter int ACC_W     = nn_pkg::ACC_W,
   parameter int OUT_W     = nn_pkg::OUT_W,
   parameter bit RELU_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              GlobalReset,
   input  logic [PROD_W-1:0] ProductPort,
   input  logic              ProductValid,
   output logic              ProductReady,
   input  logic [ACC_W-1:0]  BiasPort,
   output logic [OUT_W-1:0]  ResultPort,
   output logic              ResultValid,
   input  logic              ResultReady,
   output logic              SatFlag
);

   import nn_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] result_q, result_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] bias_sum;
   logic [OUT_W-1:0] clip_value;
   logic             clip_sat;

   // Sign-extend the product; the bias sum wraps at ACC_W by design.
   assign prod_ext = {{(ACC_W-PROD_W){ProductPort[PROD_W-1]}}, ProductPort};
   assign bias_sum = acc_q + BiasPort;

   sat_relu #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .RELU_EN(RELU_EN)
   ) u_sat_relu (
      .sum_i  (bias_sum),
      .value_o(clip_value),
      .sat_o  (clip_sat)
   );

   assign ProductReady = (state_q == ACCUM);
   assign ResultPort   = result_q;
   assign ResultValid  = valid_q;
   assign SatFlag      = sat_q;

   // Next-state and datapath updates for the accumulate / bias / hold sequence.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      sat_d    = sat_q;
      valid_d  = valid_q;
      case (state_q)
         ACCUM: begin
            if (ProductValid) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = BIAS;
               end
            end
         end
         BIAS: begin
            result_d = clip_value;
            sat_d    = clip_sat;
            valid_d  = 1'b1;
            state_d  = HOLD;
         end
         HOLD: begin
            if (ResultReady) begin
               valid_d = 1'b0;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State register; reset discards any partial sum or pending result.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         state_q  <= ACCUM;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         sat_q    <= sat_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized bench: a ReLU and a linear instance share stimulus and are
// compared against an arithmetic model of the neuron sum.
module tb_neuron_accumulator;

   localparam int PW = 26;
   localparam int AW = 36;
   localparam int OW = 26;
   localparam int NT = 4;

   logic          clk = 1'b0;
   logic          GlobalReset = 1'b1;
   logic [PW-1:0] ProductPort = '0;
   logic          ProductValid = 1'b0;
   logic [AW-1:0] BiasPort = '0;
   logic          ResultReady = 1'b1;

   logic          pr_r, pr_l, rv_r, rv_l, sf_r, sf_l;
   logic [OW-1:0] rp_r, rp_l;

   int n_checks = 0;
   int n_fail   = 0;

   longint cur_p[NT];
   longint cur_bias;

   always #5 clk = ~clk;

   neuron_accumulator #(.NUM_TERMS(NT), .RELU_EN(1'b1)) u_relu (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .ProductPort (ProductPort),
      .ProductValid(ProductValid),
      .ProductReady(pr_r),
      .BiasPort    (BiasPort),
      .ResultPort  (rp_r),
      .ResultValid (rv_r),
      .ResultReady (ResultReady),
      .SatFlag     (sf_r)
   );

   neuron_accumulator #(.NUM_TERMS(NT), .RELU_EN(1'b0)) u_lin (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .ProductPort (ProductPort),
      .ProductValid(ProductValid),
      .ProductReady(pr_l),
      .BiasPort    (BiasPort),
      .ResultPort  (rp_l),
      .ResultValid (rv_l),
      .ResultReady (ResultReady),
      .SatFlag     (sf_l)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: plain sum, wrap to AW bits, then ReLU / saturate to OW bits.
   function automatic void model(input bit relu, output longint val, output longint sat);
      longint s, lim_hi, lim_lo;
      lim_hi = (longint'(1) <<< (OW - 1)) - 1;
      lim_lo = -(longint'(1) <<< (OW - 1));
      s = cur_bias;
      for (int i = 0; i < NT; i++) s += cur_p[i];
      s = (s <<< (64 - AW)) >>> (64 - AW);
      sat = 0;
      if (relu && s < 0)      val = 0;
      else if (s > lim_hi)    begin val = lim_hi; sat = 1; end
      else if (s < lim_lo)    begin val = lim_lo; sat = 1; end
      else                    val = s;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, {rv_r, rv_l}, 0);
      check_eq({tag, "_pready"}, {pr_r, pr_l}, 3);
      check_eq({tag, "_port_r"}, longint'($signed(rp_r)), 0);
      check_eq({tag, "_port_l"}, longint'($signed(rp_l)), 0);
      check_eq({tag, "_sat"}, {sf_r, sf_l}, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      ProductValid = 1'b0;
      GlobalReset  = 1'b1;
      @(negedge clk);
      GlobalReset  = 1'b0;
      check_reset_outputs(tag);
   endtask

   task automatic send_products(input int n, input int min_gap, input int max_gap);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(min_gap, max_gap);
         repeat (gap) begin
            @(negedge clk);
            ProductValid = 1'b0;
            ProductPort  = PW'($urandom);
         end
         @(negedge clk);
         ProductValid = 1'b1;
         ProductPort  = PW'(cur_p[i]);
         check_eq("prod_ready", {pr_r, pr_l}, 3);
         @(posedge clk);
      end
   endtask

   task automatic run_frame(input string name, input int min_gap, input int max_gap,
                            input int hold, input bit rst_in_hold);
      longint ev_r, es_r, ev_l, es_l;
      int lat;
      bit seen;
      model(1'b1, ev_r, es_r);
      model(1'b0, ev_l, es_l);
      BiasPort    = AW'(cur_bias);
      ResultReady = 1'b1;
      send_products(NT, min_gap, max_gap);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 10) begin
         @(negedge clk);
         lat++;
         if (rv_r || rv_l) seen = 1'b1;
         else begin
            ProductValid = 1'($urandom_range(0, 1));
            ProductPort  = PW'($urandom);
         end
      end
      check_eq({name, "_valid"}, {rv_r, rv_l}, 3);
      if (!seen) return;
      check_eq({name, "_latency"}, lat, 2);
      check_eq({name, "_port_r"}, longint'($signed(rp_r)), ev_r);
      check_eq({name, "_sat_r"}, sf_r, es_r);
      check_eq({name, "_port_l"}, longint'($signed(rp_l)), ev_l);
      check_eq({name, "_sat_l"}, sf_l, es_l);
      check_eq({name, "_pready_lo"}, {pr_r, pr_l}, 0);
      if (hold > 0 || rst_in_hold) begin
         ResultReady = 1'b0;
         for (int h = 0; h < hold; h++) begin
            ProductValid = 1'($urandom_range(0, 1));
            ProductPort  = PW'($urandom);
            @(negedge clk);
            check_eq({name, "_hold_valid"}, {rv_r, rv_l}, 3);
            check_eq({name, "_hold_port_r"}, longint'($signed(rp_r)), ev_r);
            check_eq({name, "_hold_port_l"}, longint'($signed(rp_l)), ev_l);
            check_eq({name, "_hold_sat"}, {sf_r, sf_l}, {es_r[0], es_l[0]});
            check_eq({name, "_hold_pready"}, {pr_r, pr_l}, 0);
         end
         if (rst_in_hold) begin
            ProductValid = 1'b0;
            GlobalReset  = 1'b1;
            @(negedge clk);
            GlobalReset  = 1'b0;
            ResultReady  = 1'b1;
            check_reset_outputs({name, "_hold_rst"});
            return;
         end
      end
      ResultReady  = 1'b1;
      ProductValid = 1'($urandom_range(0, 1));
      ProductPort  = PW'($urandom);
      @(negedge clk);
      check_eq({name, "_valid_drop"}, {rv_r, rv_l}, 0);
      check_eq({name, "_pready_back"}, {pr_r, pr_l}, 3);
      ProductValid = 1'b0;
   endtask

   function automatic longint rand_product();
      logic [PW-1:0] r;
      r = PW'($urandom);
      case ($urandom_range(0, 3))
         0: return longint'($signed(r));
         1: return ($urandom_range(0, 1) != 0) ? 33554431 : -33554432;
         2: return longint'($urandom_range(0, 2000)) - 1000;
         default: return longint'($signed(r)) >>> $urandom_range(0, 20);
      endcase
   endfunction

   initial begin
      GlobalReset = 1'b1;
      repeat (3) @(negedge clk);
      GlobalReset = 1'b0;
      check_reset_outputs("reset");

      cur_p = '{400, 2000, -3, -1};          cur_bias = 0;
      run_frame("basic", 0, 0, 0, 1'b0);

      cur_p = '{-666, -198, 0, 0};           cur_bias = 0;
      run_frame("relu", 0, 1, 0, 1'b0);

      cur_p = '{33554431, 33554431, 33554431, 33554431};     cur_bias = 0;
      run_frame("sat_hi", 0, 0, 0, 1'b0);
      cur_p = '{-33554432, -33554432, -33554432, -33554432}; cur_bias = 0;
      run_frame("sat_lo", 0, 0, 0, 1'b0);

      cur_p = '{100, 100, 100, 100};         cur_bias = -500;
      run_frame("bias_neg", 1, 3, 0, 1'b0);
      cur_bias = 50;
      run_frame("bias_pos", 1, 3, 0, 1'b0);

      cur_p = '{100, 200, 300, 400};         cur_bias = 0;
      run_frame("backpr", 0, 0, 5, 1'b0);
      cur_p = '{1, 1, 1, 1};
      run_frame("after_bp", 0, 0, 0, 1'b0);

      cur_p = '{7, 9, 0, 0};
      send_products(2, 0, 0);
      do_reset("mid_rst");
      cur_p = '{1, 2, 3, 4};                 cur_bias = 0;
      run_frame("post_rst", 0, 1, 0, 1'b0);
      cur_p = '{5, 5, 5, 5};
      run_frame("hold_rst", 0, 0, 2, 1'b1);
      cur_p = '{-1, 2, -3, 4};               cur_bias = 10;
      run_frame("post_hold", 0, 0, 0, 1'b0);

      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < NT; i++) cur_p[i] = rand_product();
         cur_bias = longint'($signed($urandom())) >>> $urandom_range(0, 31);
         run_frame($sformatf("rand%0d", f), 0, 2, $urandom_range(0, 3), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
